// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the clearable synchronous RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Width of one byte lane in the write mask
    localparam int c_byte_w = 8;

    // Controller states: normal user access, or sweeping zeros into the array
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bank
//  Description : Storage array with one byte-enabled write port and one
//                registered read port. The read register only updates on
//                an enabled read and is zeroed by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_bank
    import ram_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_i,
    input  logic [D_WIDTH/c_byte_w-1:0]   be_i,
    input  logic [A_WIDTH-1:0]            waddr_i,
    input  logic [D_WIDTH-1:0]            wdata_i,
    input  logic                          re_i,
    input  logic [A_WIDTH-1:0]            raddr_i,
    output logic [D_WIDTH-1:0]            rdata_o
);

    localparam int c_nb = D_WIDTH / c_byte_w;

    logic [D_WIDTH-1:0] mem_q [A_MAX];
    logic [D_WIDTH-1:0] rdata_q;
    logic [D_WIDTH-1:0] w_bit_mask;

    // Expand the per-byte enables into a per-bit mask
    for (genvar gi = 0; gi < c_nb; gi++) begin : g_byte
        assign w_bit_mask[gi*c_byte_w +: c_byte_w] = {c_byte_w{be_i[gi]}};
    end

    // Write port: merge enabled bytes into the addressed word
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= (mem_q[waddr_i] & ~w_bit_mask) | (wdata_i & w_bit_mask);
        end
    end

    // Read port: capture the addressed word, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : ram_bank
`default_nettype wire

// File: rtl/ram_sync_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sync_clr
//  Description : Single-clock RAM with byte-enabled writes, registered reads,
//                write-first same-address forwarding and a sequential clear
//                engine that zeroes every word after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_clr
    import ram_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    output logic                          busy,
    input  logic                          write_enable,
    input  logic [D_WIDTH/c_byte_w-1:0]   byte_enable,
    input  logic [A_WIDTH-1:0]            address_write,
    input  logic [D_WIDTH-1:0]            data_write,
    input  logic                          read_enable,
    input  logic [A_WIDTH-1:0]            address_read,
    output logic [D_WIDTH-1:0]            data_read,
    output logic                          read_valid
);

    localparam int                 c_nb   = D_WIDTH / c_byte_w;
    localparam logic [A_WIDTH-1:0] c_last = A_WIDTH'(A_MAX - 1);
    localparam logic [A_WIDTH:0]   c_amax = (A_WIDTH + 1)'(A_MAX);

    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   cnt_q, cnt_d;
    logic                 rvalid_q;
    logic                 zero_q;
    logic [c_nb-1:0]      fmask_q;
    logic [D_WIDTH-1:0]   fdata_q;

    logic                 w_idle;
    logic                 w_clr_wr;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_bank_we;
    logic [c_nb-1:0]      w_bank_be;
    logic [A_WIDTH-1:0]   w_bank_waddr;
    logic [D_WIDTH-1:0]   w_bank_wdata;
    logic [D_WIDTH-1:0]   w_bank_rdata;
    logic [D_WIDTH-1:0]   w_data_read;

    // Reset holds off user traffic; otherwise only IDLE accepts accesses
    assign w_idle        = (state_q == IDLE) && !rst;
    assign w_clr_wr      = (state_q == CLEAR) && !rst;
    assign w_wr_in_range = ({1'b0, address_write} < c_amax);
    assign w_rd_in_range = ({1'b0, address_read}  < c_amax);
    assign w_wr_acc      = w_idle && write_enable && w_wr_in_range;
    assign w_rd_acc      = w_idle && read_enable;

    // The clear engine owns the write port while busy
    assign w_bank_we    = w_wr_acc || w_clr_wr;
    assign w_bank_be    = w_clr_wr ? '1    : byte_enable;
    assign w_bank_waddr = w_clr_wr ? cnt_q : address_write;
    assign w_bank_wdata = w_clr_wr ? '0    : data_write;

    // State register and clear counter; reset restarts the sweep at word 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: clear is only sampled in IDLE, sweep ends after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == c_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Read side-band: valid pulse, out-of-range flag and same-edge write bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            zero_q   <= 1'b1;
            fmask_q  <= '0;
            fdata_q  <= '0;
        end else begin
            rvalid_q <= w_rd_acc;
            if (w_rd_acc) begin
                zero_q  <= !w_rd_in_range;
                fmask_q <= (w_wr_acc && (address_write == address_read)) ? byte_enable : '0;
                fdata_q <= data_write;
            end
        end
    end

    // Output merge: forwarded bytes override stored ones, out-of-range reads give zero
    always_comb begin
        w_data_read = w_bank_rdata;
        for (int i = 0; i < c_nb; i++) begin
            if (fmask_q[i]) begin
                w_data_read[i*c_byte_w +: c_byte_w] = fdata_q[i*c_byte_w +: c_byte_w];
            end
        end
        if (zero_q) begin
            w_data_read = '0;
        end
    end

    ram_bank #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .A_MAX   (A_MAX)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_bank_we),
        .be_i    (w_bank_be),
        .waddr_i (w_bank_waddr),
        .wdata_i (w_bank_wdata),
        .re_i    (w_rd_acc && w_rd_in_range),
        .raddr_i (address_read),
        .rdata_o (w_bank_rdata)
    );

    assign busy       = (state_q == CLEAR);
    assign read_valid = rvalid_q;
    assign data_read  = w_data_read;

endmodule : ram_sync_clr
`default_nettype wire

// File: tb/tb_ram_sync_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sync_clr
//  Description : Directed bench for ram_sync_clr. A full-depth instance and a
//                shallow instance (A_MAX=20) share stimulus so that
//                out-of-range accesses can be exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        we;
    logic [1:0]  be;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        busy1, busy2;
    logic [15:0] rd1, rd2;
    logic        rv1, rv2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_sync_clr #(.D_WIDTH(16), .A_WIDTH(5), .A_MAX(32)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
        .write_enable(we), .byte_enable(be), .address_write(wa), .data_write(wd),
        .read_enable(re), .address_read(ra), .data_read(rd1), .read_valid(rv1)
    );

    ram_sync_clr #(.D_WIDTH(16), .A_WIDTH(5), .A_MAX(20)) u_dut_s (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy2),
        .write_enable(we), .byte_enable(be), .address_write(wa), .data_write(wd),
        .read_enable(re), .address_read(ra), .data_read(rd2), .read_valid(rv2)
    );

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic        ev1;
        logic [15:0] ed1;
        logic        ev2;
        logic [15:0] ed2;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n1, n2;

        rst = 1'b1; clear = 1'b0; we = 1'b0; be = 2'b00; wa = '0; wd = '0; re = 1'b0; ra = '0;

        // Vector table: inputs for one edge, expected outputs after it
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b1, 5'h1B, 1'b1, 16'h0000, 1'b1, 16'h0000});
        vq.push_back('{1'b1, 2'b11, 5'h1B, 16'hC5A3, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 2'b01, 5'h1B, 16'h00FF, 1'b0, 5'h00, 1'b0, 16'h0000, 1'b0, 16'h0000});
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b1, 5'h1B, 1'b1, 16'hC5FF, 1'b1, 16'h0000});
        vq.push_back('{1'b1, 2'b11, 5'h04, 16'hABCD, 1'b0, 5'h00, 1'b0, 16'hC5FF, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 2'b10, 5'h04, 16'h1234, 1'b1, 5'h04, 1'b1, 16'h12CD, 1'b1, 16'h12CD});
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b1, 5'h04, 1'b1, 16'h12CD, 1'b1, 16'h12CD});
        vq.push_back('{1'b1, 2'b11, 5'h14, 16'hBEEF, 1'b1, 5'h14, 1'b1, 16'hBEEF, 1'b1, 16'h0000});
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b1, 5'h14, 1'b1, 16'hBEEF, 1'b1, 16'h0000});
        vq.push_back('{1'b1, 2'b11, 5'h13, 16'h7777, 1'b0, 5'h00, 1'b0, 16'hBEEF, 1'b0, 16'h0000});
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b1, 5'h13, 1'b1, 16'h7777, 1'b1, 16'h7777});
        vq.push_back('{1'b1, 2'b01, 5'h13, 16'h5A5A, 1'b1, 5'h13, 1'b1, 16'h775A, 1'b1, 16'h775A});
        vq.push_back('{1'b1, 2'b00, 5'h04, 16'hFFFF, 1'b1, 5'h04, 1'b1, 16'h12CD, 1'b1, 16'h12CD});
        vq.push_back('{1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 5'h00, 1'b0, 16'h12CD, 1'b0, 16'h12CD});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy1}, 32'd1);
        check("reset read_valid", {31'd0, rv1}, 32'd0);
        check("reset data_read", {16'd0, rd1}, 32'd0);
        check("reset data_read small", {16'd0, rd2}, 32'd0);

        // Post-reset sweep length for both depths
        rst = 1'b0;
        n1 = 0; n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1 && !busy2) break;
            if (busy1) n1++;
            if (busy2) n2++;
            @(negedge clk);
        end
        check("reset busy cycles", n1, 32);
        check("reset busy cycles small", n2, 20);

        // Table-driven single-edge vectors
        foreach (vq[i]) begin
            we = vq[i].we; be = vq[i].be; wa = vq[i].wa; wd = vq[i].wd;
            re = vq[i].re; ra = vq[i].ra;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), {31'd0, rv1}, {31'd0, vq[i].ev1});
            check($sformatf("vec%0d data", i), {16'd0, rd1}, {16'd0, vq[i].ed1});
            check($sformatf("vec%0d valid small", i), {31'd0, rv2}, {31'd0, vq[i].ev2});
            check($sformatf("vec%0d data small", i), {16'd0, rd2}, {16'd0, vq[i].ed2});
        end
        we = 1'b0; re = 1'b0;

        // Idle cycles: no valid pulse, data held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle valid", {31'd0, rv1}, 32'd0);
            check("idle data hold", {16'd0, rd1}, 32'h12CD);
        end

        // Clear request coinciding with a write and a read: both complete
        clear = 1'b1; we = 1'b1; be = 2'b11; wa = 5'h05; wd = 16'h5555; re = 1'b1; ra = 5'h04;
        @(negedge clk);
        check("clear-edge busy", {31'd0, busy1}, 32'd1);
        check("clear-edge valid", {31'd0, rv1}, 32'd1);
        check("clear-edge data", {16'd0, rd1}, 32'h12CD);
        clear = 1'b0; wa = 5'h1B; wd = 16'hFFFF; ra = 5'h1B;
        n1 = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy1) break;
            n1++;
            check("clear valid low", {31'd0, rv1}, 32'd0);
            clear = (i == 10);
        end
        check("clear busy cycles", n1, 32);
        we = 1'b0; clear = 1'b0; ra = 5'h1B;
        @(negedge clk);
        check("after clear valid", {31'd0, rv1}, 32'd1);
        check("after clear 1B", {16'd0, rd1}, 32'h0000);
        ra = 5'h05;
        @(negedge clk);
        check("after clear 05", {16'd0, rd1}, 32'h0000);
        ra = 5'h04;
        @(negedge clk);
        check("after clear 04", {16'd0, rd1}, 32'h0000);
        re = 1'b0;

        // Reset in the middle of a clear sweep restarts it
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; re = 1'b1; ra = 5'h04;
        for (int i = 0; i < 9; i++) begin
            check("mid-clear busy", {31'd0, busy1}, 32'd1);
            check("mid-clear valid", {31'd0, rv1}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst-in-clear busy", {31'd0, busy1}, 32'd1);
            check("rst-in-clear valid", {31'd0, rv1}, 32'd0);
        end
        rst = 1'b0;
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1) break;
            n1++;
            check("restart valid low", {31'd0, rv1}, 32'd0);
            @(negedge clk);
        end
        check("restart busy cycles", n1, 32);
        @(negedge clk);
        check("restart read valid", {31'd0, rv1}, 32'd1);
        check("restart read data", {16'd0, rd1}, 32'h0000);
        re = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_sync_clr
`default_nettype wire
